// File: rtl/alu_exec.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith ops, iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ops,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: product accumulator (MUL) or partial remainder (DIV)
  // x:   multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV)
  // y:   multiplier (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, err_q, err_d, done_q, done_d;

  logic [WIDTH-1:0] op_res;
  logic             op_err;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] acc_nx, x_nx, y_nx, long_res;

  always_comb begin
    op_res = '0;
    op_err = 1'b0;
    case (ops)
      4'b0000: op_res = a & b;
      4'b0001: op_res = a | b;
      4'b0010: op_res = a + b;
      4'b0100: op_res = ~(a | b);
      4'b0110: op_res = a - b;
      4'b1000: begin
        op_res = '1;
        op_err = 1'b1;
      end
      4'b1001: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1011: op_res = {{(WIDTH-1){1'b0}}, ~a[WIDTH-1]};
      4'b0101, 4'b1101: op_res = '0;
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    rem_sh = {acc_q, x_q[WIDTH-1]};
    acc_nx = acc_q;
    x_nx   = x_q;
    y_nx   = y_q;
    if (state_q == MUL) begin
      acc_nx = y_q[0] ? acc_q + x_q : acc_q;
      x_nx   = x_q << 1;
      y_nx   = y_q >> 1;
    end else begin
      // Shifted remainder needs WIDTH+1 bits; the difference always fits WIDTH.
      if (rem_sh >= {1'b0, y_q}) begin
        acc_nx = rem_sh[WIDTH-1:0] - y_q;
        x_nx   = {x_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh[WIDTH-1:0];
        x_nx   = {x_q[WIDTH-2:0], 1'b0};
      end
    end
    long_res = (state_q == MUL) ? acc_nx : x_nx;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ops == 4'b0101 || (ops == 4'b1000 && b != '0)) begin
            state_d = (ops == 4'b0101) ? MUL : DIV;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            x_d     = a;
            y_d     = b;
          end else begin
            done_d = 1'b1;
            err_d  = op_err;
            if (ops != 4'b1101) begin
              result_d = op_res;
              zero_d   = (op_res == '0);
            end
          end
        end
      end
      MUL, DIV: begin
        acc_d = acc_nx;
        x_d   = x_nx;
        y_d   = y_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          err_d    = 1'b0;
          result_d = long_res;
          zero_d   = (long_res == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec (WIDTH=32): vector table through a
// scoreboard queue, plus hand sequences for ignored start and mid-op reset.
module tb_alu_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   ops = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, err;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ops    (ops),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   ops;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         e;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         e;
    int           edge_n;
  } exp_t;

  vec_t tv [27];
  exp_t sb [$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op starting now (just after an edge); done is searched for
  // at #1 after each following edge, counting edges after the accept edge.
  task automatic run_op(input vec_t v, input int idx);
    exp_t ex;
    exp_t got;
    int   k;
    int   busy_n;
    bit   long_op;
    long_op   = (v.ops == 4'b0101) || (v.ops == 4'b1000 && v.b != 0);
    ex.res    = v.res;
    ex.z      = v.z;
    ex.e      = v.e;
    ex.edge_n = long_op ? W : 0;
    start = 1'b1; ops = v.ops; a = v.a; b = v.b;
    sb.push_back(ex);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    busy_n = 0;
    while (!done && k < 100) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      k++;
    end
    got = sb.pop_front();
    if (!done) check($sformatf("timeout[%0d]", idx), 32'(k), 32'(got.edge_n));
    check($sformatf("result[%0d]", idx), result, got.res);
    check($sformatf("zero[%0d]", idx), W'(zero), W'(got.z));
    check($sformatf("err[%0d]", idx), W'(err), W'(got.e));
    check($sformatf("latency[%0d]", idx), W'(k), W'(got.edge_n));
    check($sformatf("busy_cycles[%0d]", idx), W'(busy_n), W'(long_op ? W : 0));
    check($sformatf("busy_at_done[%0d]", idx), W'(busy), '0);
  endtask

  initial begin
    vec_t v;
    int   k;
    int   seen;

    tv[0]  = '{4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    tv[1]  = '{4'b0110, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0};
    tv[2]  = '{4'b0101, 32'h0000FFFF,   32'h00010001,   32'hFFFFFFFF,   1'b0, 1'b0};
    tv[3]  = '{4'b1000, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0};
    tv[4]  = '{4'b1000, 32'd9,          32'd0,          32'hFFFFFFFF,   1'b0, 1'b1};
    tv[5]  = '{4'b1001, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b0};
    tv[6]  = '{4'b1011, 32'h80000000,   32'd0,          32'd0,          1'b1, 1'b0};
    tv[7]  = '{4'b1011, 32'd0,          32'd0,          32'd1,          1'b0, 1'b0};
    tv[8]  = '{4'b0100, 32'd0,          32'd0,          32'hFFFFFFFF,   1'b0, 1'b0};
    tv[9]  = '{4'b0000, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   1'b0, 1'b0};
    tv[10] = '{4'b0001, 32'h0F0F0000,   32'h0000F0F0,   32'h0F0FF0F0,   1'b0, 1'b0};
    tv[11] = '{4'b0111, 32'd3,          32'd4,          32'd0,          1'b1, 1'b1};
    tv[12] = '{4'b1101, 32'h1234,       32'h5678,       32'd0,          1'b1, 1'b0};
    tv[13] = '{4'b0010, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0};
    tv[14] = '{4'b0110, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, 1'b0};
    tv[15] = '{4'b0101, 32'd7,          32'd6,          32'd42,         1'b0, 1'b0};
    tv[16] = '{4'b0101, 32'h80000000,   32'd2,          32'd0,          1'b1, 1'b0};
    tv[17] = '{4'b1000, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0, 1'b0};
    tv[18] = '{4'b1000, 32'd7,          32'd9,          32'd0,          1'b1, 1'b0};
    tv[19] = '{4'b1001, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b1, 1'b0};
    tv[20] = '{4'b1001, 32'h80000000,   32'h7FFFFFFF,   32'd1,          1'b0, 1'b0};
    tv[21] = '{4'b0010, 32'd2,          32'd3,          32'd5,          1'b0, 1'b0};
    tv[22] = '{4'b1101, 32'd0,          32'd0,          32'd5,          1'b0, 1'b0};
    tv[23] = '{4'b1111, 32'd1,          32'd1,          32'd0,          1'b1, 1'b1};
    tv[24] = '{4'b1000, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, 1'b0};
    tv[25] = '{4'b1000, 32'hFFFFFFFE,   32'd2,          32'h7FFFFFFF,   1'b0, 1'b0};
    tv[26] = '{4'b0101, 32'd12345,      32'd1000,       32'd12345000,   1'b0, 1'b0};

    #12;
    check("reset_busy",   W'(busy), '0);
    check("reset_done",   W'(done), '0);
    check("reset_result", result,   '0);
    check("reset_zero",   W'(zero), W'(1));
    check("reset_err",    W'(err),  '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 27; i++) run_op(tv[i], i);

    // Start during busy must be dropped, not queued.
    @(posedge clk); #1;
    start = 1'b1; ops = 4'b0101; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      if (k == 5) start = 1'b1;
      if (k == 5) ops = 4'b0010;
      if (k == 5) a = 32'd1;
      if (k == 5) b = 32'd1;
      if (k == 6) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check("ign_latency", W'(k), W'(W));
    check("ign_result",  result, 32'd12);
    @(posedge clk); #1;
    check("ign_done_pulse", W'(done), '0);
    check("ign_not_queued", W'(busy), '0);
    check("ign_result_hold", result, 32'd12);

    // Reset asserted mid-multiply aborts with no done.
    start = 1'b1; ops = 4'b0101; a = 32'h0000FFFF; b = 32'h00010001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("rst_busy",   W'(busy), '0);
    check("rst_done",   W'(done), '0);
    check("rst_result", result,   '0);
    check("rst_zero",   W'(zero), W'(1));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("no_done_after_rst", W'(seen), '0);
    v = '{4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0};
    run_op(v, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
